load_cache: RTL and testbench

//  Direct-mapped, word-granular read cache between the CPU load stage and the
//  mem load port (~100-cycle latency).
//  - Hits return in 1 cycle; misses issue one mem load and fill the line.
//  - At most one memory request is outstanding at any time.
//  - Keeps hit/miss counters for performance runs.

---
 rtl/load_cache.sv | 141 ++++++++++++++
 tb/tb_load_cache.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_cache.sv
// load_cache: direct-mapped, word-granular read cache in front of a slow memory
// load port. Hits answer next cycle; a miss issues a single memory load and fills the line.
`default_nettype none

module load_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        mem_load_en,
  output logic [15:0] mem_load_addr,
  input  logic        mem_load_ready,
  input  logic [15:0] mem_load_data,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 16 - INDEX_BITS;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [15:0]         addr_q, addr_d;
  logic                resp_valid_q, resp_valid_d;
  logic [15:0]         resp_data_q, resp_data_d;
  logic                mem_load_en_q, mem_load_en_d;
  logic [15:0]         mem_load_addr_q, mem_load_addr_d;
  logic [15:0]         hit_count_q, hit_count_d;
  logic [15:0]         miss_count_q, miss_count_d;

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [15:0]         data_q [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] wait_idx;
  logic                  accept;
  logic                  hit;
  logic                  fill_en;

  assign req_idx  = req_addr[INDEX_BITS-1:0];
  assign req_tag  = req_addr[15:INDEX_BITS];
  assign wait_idx = addr_q[INDEX_BITS-1:0];
  assign accept   = req_valid && (state_q == S_IDLE);
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign mem_load_en   = mem_load_en_q;
  assign mem_load_addr = mem_load_addr_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    addr_d          = addr_q;
    resp_valid_d    = 1'b0;
    resp_data_d     = resp_data_q;
    mem_load_en_d   = 1'b0;
    mem_load_addr_d = mem_load_addr_q;
    hit_count_d     = hit_count_q;
    miss_count_d    = miss_count_q;
    fill_en         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A mem_load_ready seen here is a stale completion and is ignored.
        if (accept) begin
          if (hit) begin
            resp_valid_d = 1'b1;
            resp_data_d  = data_q[req_idx];
            hit_count_d  = (hit_count_q == 16'hFFFF) ? hit_count_q : hit_count_q + 16'd1;
          end else begin
            mem_load_en_d   = 1'b1;
            mem_load_addr_d = req_addr;
            addr_d          = req_addr;
            miss_count_d    = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
            state_d         = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_load_ready) begin
          fill_en           = 1'b1;
          valid_d[wait_idx] = 1'b1;
          resp_valid_d      = 1'b1;
          resp_data_d       = mem_load_data;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      valid_q         <= '0;
      addr_q          <= 16'h0000;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= 16'h0000;
      mem_load_en_q   <= 1'b0;
      mem_load_addr_q <= 16'h0000;
      hit_count_q     <= 16'h0000;
      miss_count_q    <= 16'h0000;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      addr_q          <= addr_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      mem_load_en_q   <= mem_load_en_d;
      mem_load_addr_q <= mem_load_addr_d;
      hit_count_q     <= hit_count_d;
      miss_count_q    <= miss_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[wait_idx]  <= addr_q[15:INDEX_BITS];
      data_q[wait_idx] <= mem_load_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_cache.sv
// tb_load_cache: directed plus randomized checks of load_cache against a
// behavioural memory and a line-presence model.
`default_nettype none

module tb_load_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        mem_load_ready = 1'b0;
  logic [15:0] mem_load_data  = 16'h0000;
  wire         req_ready;
  wire         resp_valid;
  wire  [15:0] resp_data;
  wire         mem_load_en;
  wire  [15:0] mem_load_addr;
  wire  [15:0] hit_count;
  wire  [15:0] miss_count;

  load_cache #(.INDEX_BITS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .mem_load_en   (mem_load_en),
    .mem_load_addr (mem_load_addr),
    .mem_load_ready(mem_load_ready),
    .mem_load_data (mem_load_data),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Backing memory and responder: any latency, restarts on each enable, no reset.
  logic [15:0] mem [65536];
  int          lat_cfg     = 4;
  bit          pend        = 1'b0;
  int          cnt         = 0;
  logic [15:0] maddr       = 16'h0000;
  int          en_pulses   = 0;
  int          resp_pulses = 0;

  always @(negedge clk) begin
    mem_load_ready = 1'b0;
    if (resp_valid === 1'b1) resp_pulses++;
    if (mem_load_en === 1'b1) begin
      pend  = 1'b1;
      cnt   = lat_cfg;
      maddr = mem_load_addr;
      en_pulses++;
    end else if (pend) begin
      if (cnt == 0) begin
        mem_load_ready = 1'b1;
        mem_load_data  = mem[maddr];
        pend           = 1'b0;
      end else begin
        cnt--;
      end
    end
  end

  // Reference: which lines hold which address, plus saturating counts.
  bit          mv [16];
  logic [11:0] mt [16];
  int          m_hits = 0;
  int          m_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic do_req(input logic [15:0] a, input bit junk);
    int idx;
    int e0;
    bit h;
    bit got;
    idx = int'(a[3:0]);
    h   = mv[idx] && (mt[idx] == a[15:4]);
    e0  = en_pulses;
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    if (h) begin
      if (m_hits < 65535) m_hits++;
      chk("hit_resp_valid", 32'(resp_valid), 1);
      chk("hit_data", 32'(resp_data), 32'(mem[a]));
      chk("hit_no_mem_load", en_pulses, e0);
    end else begin
      if (m_miss < 65535) m_miss++;
      chk("miss_load_en", 32'(mem_load_en), 1);
      chk("miss_load_addr", 32'(mem_load_addr), 32'(a));
      chk("miss_no_early_resp", 32'(resp_valid), 0);
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
        if (junk) begin
          req_valid = 1'b1;
          req_addr  = 16'($urandom);
        end
        step();
        if (resp_valid === 1'b1) got = 1'b1;
        else if (junk) chk("wait_ready_low", 32'(req_ready), 0);
      end
      req_valid = 1'b0;
      chk("miss_resp_seen", 32'(got), 1);
      chk("miss_data", 32'(resp_data), 32'(mem[a]));
      chk("single_mem_load", en_pulses, e0 + 1);
      mv[idx] = 1'b1;
      mt[idx] = a[15:4];
    end
    chk("hit_count", 32'(hit_count), m_hits);
    chk("miss_count", 32'(miss_count), m_miss);
    step();
    chk("resp_pulse_end", 32'(resp_valid), 0);
  endtask

  logic [15:0] list [4];
  int          r0;
  int          n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0010] = 16'hBEEF;
    list[0] = 16'h0010;
    list[1] = 16'h1231;
    list[2] = 16'h0A52;
    list[3] = 16'h7FF3;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 16'h0000;
    model_reset();
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_load_en", 32'(mem_load_en), 0);
    chk("rst_load_addr", 32'(mem_load_addr), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_miss_count", 32'(miss_count), 0);
    rst_n = 1'b1;
    step();

    // Cold miss with long memory latency, then hit, then index conflict.
    lat_cfg = 100;
    do_req(16'h0010, 1'b0);
    chk("first_data_beef", 32'(resp_data), 32'h0000BEEF);
    lat_cfg = 5;
    do_req(16'h0010, 1'b0);
    chk("hit_beef", 32'(resp_data), 32'h0000BEEF);
    do_req(16'h0020, 1'b0);
    do_req(16'h0010, 1'b0);
    chk("conflict_misses", 32'(miss_count), 3);

    // Requests presented while waiting must be refused.
    lat_cfg = 12;
    r0 = resp_pulses;
    do_req(16'h1234, 1'b1);
    chk("wait_single_resp", resp_pulses, r0 + 1);

    // Reset mid-wait, then a stale completion arrives in idle.
    lat_cfg   = 40;
    req_valid = 1'b1;
    req_addr  = 16'h0555;
    step();
    req_valid = 1'b0;
    chk("pre_rst_load_en", 32'(mem_load_en), 1);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(req_ready), 1);
    chk("async_rst_miss_count", 32'(miss_count), 0);
    chk("async_rst_resp_data", 32'(resp_data), 0);
    model_reset();
    step();
    rst_n = 1'b1;
    r0 = resp_pulses;
    repeat (60) step();
    chk("stale_ready_no_resp", resp_pulses, r0);
    chk("stale_ready_pend_done", 32'(pend), 0);
    lat_cfg = 3;
    do_req(16'h0010, 1'b0);
    chk("post_rst_refill_miss", 32'(miss_count), 1);

    // Fill four lines, then hit them back to back.
    for (int i = 0; i < 4; i++) do_req(list[i], 1'b0);
    req_valid = 1'b1;
    req_addr  = list[0];
    for (int i = 0; i < 4; i++) begin
      step();
      chk("b2b_valid", 32'(resp_valid), 1);
      chk("b2b_data", 32'(resp_data), 32'(mem[list[i]]));
      if (i < 3) req_addr = list[i + 1];
      else       req_valid = 1'b0;
    end
    m_hits += 4;
    step();
    chk("b2b_end", 32'(resp_valid), 0);
    chk("b2b_hit_count", 32'(hit_count), m_hits);

    // Random mix over a small address pool to exercise hits and conflicts.
    for (int t = 0; t < 40; t++) begin
      lat_cfg = int'($urandom_range(1, 8));
      do_req(16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Drive the hit counter to saturation and beyond.
    do_req(16'h0010, 1'b0);
    n = 65535 - m_hits;
    req_valid = 1'b1;
    req_addr  = 16'h0010;
    repeat (n) step();
    chk("sat_reach", 32'(hit_count), 32'h0000FFFF);
    repeat (3) step();
    req_valid = 1'b0;
    step();
    m_hits = 65535;
    chk("sat_hold", 32'(hit_count), 32'h0000FFFF);
    chk("sat_data", 32'(resp_data), 32'h0000BEEF);
    chk("sat_miss_count", 32'(miss_count), m_miss);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
